// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state, floor types, floor limits and mask helpers
// for the 3-floor elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;
  typedef logic [1:0] floor_t;

  localparam int     NUM_FLOORS = 3;
  localparam floor_t FLOOR_MIN  = 2'd1;
  localparam floor_t FLOOR_MAX  = 2'd3;

  // One-hot request bit for a floor number (floor 1 -> bit0).
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
    case (f)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Request bits strictly above a floor.
  function automatic logic [NUM_FLOORS-1:0] floor_above(input floor_t f);
    case (f)
      2'd1:    return 3'b110;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Request bits strictly below a floor.
  function automatic logic [NUM_FLOORS-1:0] floor_below(input floor_t f);
    case (f)
      2'd2:    return 3'b001;
      2'd3:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/elevator_car_ctrl_timer.sv
// down_timer: loadable down-counter with a done flag; one instance is
// shared between floor-segment travel timing and door dwell timing.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; decrement stops at zero so done stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: 3-floor car sequencer producing M (moving) and the
// one-hot aligned flags A1..A3 for the door-enable logic. M and any A bit
// are never high together. Build option ELEVATOR_ESTOP_EN adds an estop
// input that freezes travel and dwell while calls keep being latched.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] call,
`ifdef ELEVATOR_ESTOP_EN
  input  logic       estop,
`endif
  output logic       M,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       dir_up,
  output logic [2:0] pending
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  state_t      r_state;
  floor_t      r_floor;
  logic        r_dir_up;
  logic        r_M;
  logic [2:0]  r_aligned;
  logic [2:0]  r_pending;

  logic          w_estop;
  logic [2:0]    w_floor_oh;
  logic [2:0]    w_above;
  logic [2:0]    w_below;
  logic          w_here;
  logic          w_go_up;
  logic          w_go_down;
  floor_t        w_next_floor;
  logic [2:0]    w_next_oh;
  logic          w_arrive;
  logic          w_hold_call;
  logic          w_tmr_done;
  logic          w_tmr_load;
  logic          w_tmr_dec;
  logic [TW-1:0] w_tmr_value;
  logic [2:0]    w_clr;

`ifdef ELEVATOR_ESTOP_EN
  assign w_estop = estop;
`else
  assign w_estop = 1'b0;
`endif

  assign w_floor_oh   = floor_onehot(r_floor);
  assign w_above      = r_pending & floor_above(r_floor);
  assign w_below      = r_pending & floor_below(r_floor);
  assign w_here       = |(r_pending & w_floor_oh);
  assign w_go_up      = (|w_above) && (r_dir_up || !(|w_below));
  assign w_go_down    = !w_go_up && (|w_below);
  assign w_next_floor = r_dir_up ? (r_floor + 2'd1) : (r_floor - 2'd1);
  assign w_next_oh    = floor_onehot(w_next_floor);
  // Stopping at the end of the shaft keeps the floor inside 1..3 even if no request is found there.
  assign w_arrive     = (|(r_pending & w_next_oh)) ||
                        (w_next_floor == (r_dir_up ? FLOOR_MAX : FLOOR_MIN));
  assign w_hold_call  = |(call & w_floor_oh);

  // Timer load/decrement and pending-clear mask, decided from the current state.
  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_dec   = 1'b0;
    w_tmr_value = TRAVEL_LOAD;
    w_clr       = 3'b000;
    if (r_state == DWELL) begin
      w_clr = w_floor_oh;
    end
    if (!w_estop) begin
      case (r_state)
        IDLE: begin
          if (w_here) begin
            w_tmr_load  = 1'b1;
            w_tmr_value = DOOR_LOAD;
            w_clr       = w_floor_oh;
          end else if (w_go_up || w_go_down) begin
            w_tmr_load  = 1'b1;
          end
        end
        MOVE: begin
          if (w_tmr_done) begin
            w_tmr_load = 1'b1;
            if (w_arrive) begin
              w_tmr_value = DOOR_LOAD;
              w_clr       = w_next_oh;
            end
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        DWELL: begin
          if (w_hold_call) begin
            w_tmr_load  = 1'b1;
            w_tmr_value = DOOR_LOAD;
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  down_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tmr_load),
    .i_dec   (w_tmr_dec),
    .i_value (w_tmr_value),
    .o_done  (w_tmr_done)
  );

  // Car FSM: state, floor, direction, request latch and registered M/A outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_floor   <= FLOOR_MIN;
      r_dir_up  <= 1'b1;
      r_M       <= 1'b0;
      r_aligned <= 3'b001;
      r_pending <= 3'b000;
    end else begin
      r_pending <= (r_pending | call) & ~w_clr;
      if (!w_estop) begin
        case (r_state)
          IDLE: begin
            if (w_here) begin
              r_state <= DWELL;
            end else if (w_go_up) begin
              r_state   <= MOVE;
              r_dir_up  <= 1'b1;
              r_M       <= 1'b1;
              r_aligned <= 3'b000;
            end else if (w_go_down) begin
              r_state   <= MOVE;
              r_dir_up  <= 1'b0;
              r_M       <= 1'b1;
              r_aligned <= 3'b000;
            end
          end
          MOVE: begin
            r_M       <= 1'b1;
            r_aligned <= 3'b000;
            if (w_tmr_done) begin
              r_floor <= w_next_floor;
              if (w_arrive) begin
                r_state   <= DWELL;
                r_M       <= 1'b0;
                r_aligned <= w_next_oh;
              end
            end
          end
          DWELL: begin
            if (w_tmr_done && !w_hold_call) begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end else if (r_state == MOVE) begin
        r_M       <= 1'b0;
        r_aligned <= 3'b000;
      end
    end
  end

  assign M       = r_M;
  assign A1      = r_aligned[0];
  assign A2      = r_aligned[1];
  assign A3      = r_aligned[2];
  assign dir_up  = r_dir_up;
  assign pending = r_pending;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb_elevator_car_ctrl: directed self-checking bench for elevator_car_ctrl
// with TRAVEL_CYCLES=4 and DOOR_CYCLES=3. Expected timelines are worked
// out by hand from the call edge. Estop checks need ELEVATOR_ESTOP_EN.
module tb_elevator_car_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] call;
  logic       estop;
  logic       M, A1, A2, A3, dir_up;
  logic [2:0] pending;
  logic [3:0] status;

  int compCount = 0;
  int failCount = 0;

  assign status = {M, A3, A2, A1};

  elevator_car_ctrl #(
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .call    (call),
`ifdef ELEVATOR_ESTOP_EN
    .estop   (estop),
`endif
    .M       (M),
    .A1      (A1),
    .A2      (A2),
    .A3      (A3),
    .dir_up  (dir_up),
    .pending (pending)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tickClock();
    @(posedge clk);
    #1;
  endtask

  // Present a call pattern for exactly one rising edge.
  task automatic applyStimulus(input logic [2:0] value);
    call = value;
    tickClock();
    call = 3'b000;
  endtask

  // Run cycles expecting a fixed {M,A3,A2,A1} and no M/A overlap.
  task automatic expectPhase(input string tag, input int cycles, input logic [3:0] expStatus);
    for (int i = 0; i < cycles; i++) begin
      tickClock();
      checkOutput(tag, status, expStatus);
      checkOutput("MxA", M & (A1 | A2 | A3), 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    call  = 3'b000;
    estop = 1'b0;
    repeat (2) tickClock();
    checkOutput("rst_status", status, 4'b0001);
    checkOutput("rst_pending", pending, 3'b000);
    checkOutput("rst_dir", dir_up, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    expectPhase("idle_hold", 10, 4'b0001);
    checkOutput("idle_pending", pending, 3'b000);
    checkOutput("idle_dir", dir_up, 1'b1);

    $display("[TB] floor 1 -> 3 passing floor 2");
    applyStimulus(3'b100);
    checkOutput("f3_latched", pending, 3'b100);
    checkOutput("f3_not_yet", status, 4'b0001);
    expectPhase("f3_move", 8, 4'b1000);
    expectPhase("f3_dwell", 3, 4'b0100);
    checkOutput("f3_cleared", pending, 3'b000);
    expectPhase("f3_idle", 1, 4'b0100);
    checkOutput("f3_dir", dir_up, 1'b1);

    $display("[TB] floor 3 -> 1, then 1 -> 2");
    applyStimulus(3'b001);
    expectPhase("f1_move", 8, 4'b1000);
    expectPhase("f1_dwell", 4, 4'b0001);
    checkOutput("f1_dir", dir_up, 1'b0);
    applyStimulus(3'b010);
    expectPhase("f2_move", 4, 4'b1000);
    expectPhase("f2_dwell", 4, 4'b0010);
    checkOutput("f2_dir", dir_up, 1'b1);

    $display("[TB] two-sided call from floor 2 going up");
    applyStimulus(3'b101);
    checkOutput("both_latched", pending, 3'b101);
    expectPhase("both_up", 4, 4'b1000);
    checkOutput("both_up_dir", dir_up, 1'b1);
    expectPhase("both_a3", 4, 4'b0100);
    checkOutput("both_left", pending, 3'b001);
    expectPhase("both_down", 8, 4'b1000);
    checkOutput("both_down_dir", dir_up, 1'b0);
    expectPhase("both_a1", 4, 4'b0001);
    checkOutput("both_done", pending, 3'b000);

    $display("[TB] call at current floor with door hold");
    applyStimulus(3'b001);
    checkOutput("here_latched", pending, 3'b001);
    checkOutput("here_stat0", status, 4'b0001);
    tickClock();
    checkOutput("here_cleared", pending, 3'b000);
    checkOutput("here_stat1", status, 4'b0001);
    call = 3'b101;
    tickClock();
    checkOutput("hold_no_latch", pending, 3'b100);
    call = 3'b001;
    tickClock();
    call = 3'b000;
    checkOutput("hold_pending", pending, 3'b100);
    expectPhase("hold_stay", 3, 4'b0001);
    expectPhase("hold_leave", 8, 4'b1000);
    expectPhase("hold_a3", 4, 4'b0100);
    checkOutput("hold_done", pending, 3'b000);

    $display("[TB] asynchronous reset during travel");
    applyStimulus(3'b001);
    expectPhase("pre_rst_move", 2, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_status", status, 4'b0001);
    checkOutput("arst_pending", pending, 3'b000);
    checkOutput("arst_dir", dir_up, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    expectPhase("post_rst", 6, 4'b0001);
    checkOutput("post_rst_pending", pending, 3'b000);

`ifdef ELEVATOR_ESTOP_EN
    $display("[TB] estop for 5 cycles mid-segment");
    applyStimulus(3'b010);
    expectPhase("es_move", 2, 4'b1000);
    estop = 1'b1;
    expectPhase("es_frozen", 5, 4'b0000);
    estop = 1'b0;
    expectPhase("es_resume", 2, 4'b1000);
    expectPhase("es_a2", 4, 4'b0010);
    checkOutput("es_pending", pending, 3'b000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
